// File: rtl/issue_skip_ctrl.sv
// -----------------------------------------------------------------------------
// issue_skip_ctrl
//
// Issue-side controller for index-compressed execution. Each accepted upstream
// word is either fired into the execution pipeline or routed around it on the
// thru/skip path. Every issued word receives an in-order sequence tag. A credit
// counter bounds the outstanding words to the capacity of the downstream
// reorder buffer. A release token is drained through the pipeline before it is
// issued, and the tag is cleared only after the buffer has emptied.
//
// Optional feature: define ISSUE_SKIP_ZERO_EN to send words with d==0 on the
// skip path. Without it, every word is fired and O_TS/O_TSFTk stay 0.
//
// Ports
//   clock      : clock
//   reset      : synchronous, active-high reset
//   I_Active   : module enable; when 0, nothing is accepted or issued
//   I_FTk      : upstream forward token (.v valid, .r release, .d data)
//   O_BTk      : back token to upstream; only .n (nack) is driven, combinational
//   I_BTk      : back token from the execution/output side; .n stalls issue
//   I_Retire   : one pulse per word dequeued by the output buffer (returns a credit)
//   O_FTk      : operand token to the first execution stage (registered)
//   O_Fired    : word issued to execution this cycle (registered)
//   O_TSFTk    : thru/skip token to the output buffer (registered)
//   O_TS       : word issued on the skip path this cycle (registered)
//   O_Tag      : sequence tag of the word issued this cycle (registered)
//   O_Busy     : state is not IDLE, or credits are outstanding
// -----------------------------------------------------------------------------
package issue_skip_pkg;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              v;
        logic              r;
        logic [DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
    } BTk_t;
endpackage

module issue_skip_ctrl
    import issue_skip_pkg::*;
#(
    parameter int SIZE_OUT_BUFF = 5,
    parameter int PIPE_DEPTH    = 5,
    parameter int LOG_SIZE_BUFF = $clog2(SIZE_OUT_BUFF)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Active,
    input  FTk_t                     I_FTk,
    output BTk_t                     O_BTk,
    input  BTk_t                     I_BTk,
    input  logic                     I_Retire,
    output FTk_t                     O_FTk,
    output logic                     O_Fired,
    output FTk_t                     O_TSFTk,
    output logic                     O_TS,
    output logic [LOG_SIZE_BUFF-1:0] O_Tag,
    output logic                     O_Busy
);

    localparam int CNT_W  = $clog2(SIZE_OUT_BUFF + 1);
    localparam int WAIT_W = $clog2(PIPE_DEPTH + 1);

    localparam logic [CNT_W-1:0]         CNT_MAX   = CNT_W'(SIZE_OUT_BUFF);
    localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]         CNT_ZERO  = CNT_W'(0);
    localparam logic [LOG_SIZE_BUFF-1:0] TAG_LAST  = LOG_SIZE_BUFF'(SIZE_OUT_BUFF - 1);
    localparam logic [LOG_SIZE_BUFF-1:0] TAG_ONE   = LOG_SIZE_BUFF'(1);
    localparam logic [LOG_SIZE_BUFF-1:0] TAG_ZERO  = LOG_SIZE_BUFF'(0);
    localparam logic [WAIT_W-1:0]        WAIT_LOAD = WAIT_W'(PIPE_DEPTH);
    localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]        WAIT_ZERO = WAIT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_REL   = 3'd3,
        ST_WCLR  = 3'd4
    } state_t;

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [LOG_SIZE_BUFF-1:0] tag_r;
    logic [WAIT_W-1:0]        wait_r;

    FTk_t                     ftk_r;
    FTk_t                     tsftk_r;
    logic                     fired_r;
    logic                     ts_r;
    logic [LOG_SIZE_BUFF-1:0] tag_out_r;

    logic                     acc_s;
    logic                     rel_issue_s;
    logic                     issue_s;
    logic                     skip_s;
    logic                     nack_s;
    logic                     has_credit_s;
    logic                     rel_seen_s;
    logic [CNT_W-1:0]         cnt_next_s;
    logic [LOG_SIZE_BUFF-1:0] tag_inc_s;
    FTk_t                     rel_tok_s;

    // Accept, steering, nack and credit/tag next-value decode
    always_comb begin
        has_credit_s = (cnt_r < CNT_MAX);
        rel_seen_s   = I_FTk.v & I_FTk.r;
        acc_s        = I_Active & ~I_BTk.n
                     & ((state_r == ST_IDLE) | (state_r == ST_RUN))
                     & I_FTk.v & ~I_FTk.r & has_credit_s;
        rel_issue_s  = I_Active & (state_r == ST_REL);
        issue_s      = acc_s | rel_issue_s;

`ifdef ISSUE_SKIP_ZERO_EN
        skip_s = acc_s & (I_FTk.d == {DATA_W{1'b0}});
`else
        skip_s = 1'b0;
`endif

        // The release token is acknowledged in the cycle it is issued.
        if (reset) begin
            nack_s = 1'b0;
        end else begin
            nack_s = I_Active & I_FTk.v & ~acc_s & ~rel_issue_s;
        end

        // Issue and retire together leave the count unchanged; a retire with
        // nothing outstanding is ignored.
        if (issue_s && !I_Retire) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else if (!issue_s && I_Retire && (cnt_r != CNT_ZERO)) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end

        // Tag wraps explicitly so a non power-of-2 buffer size works.
        if (tag_r == TAG_LAST) begin
            tag_inc_s = TAG_ZERO;
        end else begin
            tag_inc_s = tag_r + TAG_ONE;
        end

        rel_tok_s   = '{v: 1'b1, r: 1'b1, d: I_FTk.d};
        O_BTk       = '0;
        O_BTk.n     = nack_s;
    end

    // Control FSM, credit counter, tag allocator and registered issue outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            tag_r     <= TAG_ZERO;
            wait_r    <= WAIT_ZERO;
            ftk_r     <= '0;
            tsftk_r   <= '0;
            fired_r   <= 1'b0;
            ts_r      <= 1'b0;
            tag_out_r <= TAG_ZERO;
        end else begin
            fired_r   <= 1'b0;
            ts_r      <= 1'b0;
            ftk_r     <= '0;
            tsftk_r   <= '0;
            tag_out_r <= TAG_ZERO;
            cnt_r     <= cnt_next_s;

            if (skip_s) begin
                ts_r      <= 1'b1;
                tsftk_r   <= I_FTk;
                tag_out_r <= tag_r;
            end else if (acc_s) begin
                fired_r   <= 1'b1;
                ftk_r     <= I_FTk;
                tag_out_r <= tag_r;
            end else if (rel_issue_s) begin
                fired_r   <= 1'b1;
                ftk_r     <= rel_tok_s;
                tag_out_r <= tag_r;
            end

            if (issue_s) begin
                tag_r <= tag_inc_s;
            end

            if (I_Active) begin
                case (state_r)
                    ST_IDLE: begin
                        if (acc_s) begin
                            state_r <= ST_RUN;
                        end else if (rel_seen_s && (cnt_r == CNT_ZERO)) begin
                            state_r <= ST_REL;
                        end
                    end
                    ST_RUN: begin
                        if (rel_seen_s) begin
                            state_r <= ST_DRAIN;
                            wait_r  <= WAIT_LOAD;
                        end
                    end
                    ST_DRAIN: begin
                        // Let in-flight words clear the pipeline before release.
                        if (wait_r == WAIT_ZERO) begin
                            if (!I_BTk.n && has_credit_s) begin
                                state_r <= ST_REL;
                            end
                        end else begin
                            wait_r <= wait_r - WAIT_ONE;
                        end
                    end
                    ST_REL: begin
                        state_r <= ST_WCLR;
                    end
                    ST_WCLR: begin
                        if (cnt_r == CNT_ZERO) begin
                            tag_r   <= TAG_ZERO;
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign O_FTk   = ftk_r;
    assign O_TSFTk = tsftk_r;
    assign O_Fired = fired_r;
    assign O_TS    = ts_r;
    assign O_Tag   = tag_out_r;
    assign O_Busy  = (state_r != ST_IDLE) | (cnt_r != CNT_ZERO);

endmodule
